axi_slv_wr_mem: RTL and testbench

Write-channel AXI slave that sits directly downstream of the AXI master agent interface. It accepts write bursts on the AW and W channels, stores strobed data into an internal word-addressed memory, and returns one B response per burst. It is the bench's first synthesizable write-side target, and it checks the master's burst legality (length, last, ID, burst type, range).

---
 rtl/axi_slv_wr_mem_if.sv | 42 ++++
 rtl/axi_slv_wr_mem.sv | 170 +++++++++++++++++
 tb/tb_axi_slv_wr_mem.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slv_wr_mem_if.sv
// rtl/axi_slv_wr_mem_if.sv - AW/W/B channel bundle between a write master and axi_slv_wr_mem
interface axi_slv_wr_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] AW_ADDR_q;
  logic [3:0]            AW_ID;
  logic [3:0]            AW_LEN;
  logic [2:0]            AW_SIZE;
  logic [1:0]            AW_BURST;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [31:0]           W_DATA;
  logic [3:0]            W_STRB;
  logic                  W_LAST;
  logic [3:0]            W_ID;
  logic                  WVALID;
  logic                  WREADY;

  logic [3:0]            B_ID;
  logic [1:0]            B_RESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AW_ADDR_q, AW_ID, AW_LEN, AW_SIZE, AW_BURST, AWVALID,
    input  AWREADY,
    output W_DATA, W_STRB, W_LAST, W_ID, WVALID,
    input  WREADY,
    input  B_ID, B_RESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AW_ADDR_q, AW_ID, AW_LEN, AW_SIZE, AW_BURST, AWVALID,
    output AWREADY,
    input  W_DATA, W_STRB, W_LAST, W_ID, WVALID,
    output WREADY,
    output B_ID, B_RESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/axi_slv_wr_mem.sv
// rtl/axi_slv_wr_mem.sv - AXI write-channel slave into word memory; AXI_SLV_WRAP_EN enables WRAP bursts
module axi_slv_wr_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  axi_slv_wr_mem_if.slave              bus,
  input  logic [$clog2(MEM_DEPTH)-1:0] DBG_ADDR,
  output logic [DATA_WIDTH-1:0]        DBG_DATA
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e                state_q, state_d;
  logic                  rdy_en_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            id_q, id_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  burst_err_q, burst_err_d;
  logic                  slverr_q, slverr_d;
  logic                  decerr_q, decerr_d;

  logic                  aw_ready, w_ready, b_valid;
  logic                  aw_hs, w_hs, b_hs;
  logic                  aw_err, last_beat, beat_oor, wr_en;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [ADDR_WIDTH-1:0] incr, next_addr;
`ifdef AXI_SLV_WRAP_EN
  logic [ADDR_WIDTH-1:0] aw_mask, bound;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // rdy_en_q keeps AWREADY low through reset and for the edge that releases it
  assign aw_ready = rdy_en_q && (state_q == IDLE);
  assign w_ready  = (state_q == DATA);
  assign b_valid  = (state_q == RESP);

  assign bus.AWREADY = aw_ready;
  assign bus.WREADY  = w_ready;
  assign bus.BVALID  = b_valid;
  assign bus.B_ID    = id_q;
  assign bus.B_RESP  = decerr_q ? 2'b11 : (slverr_q ? 2'b10 : 2'b00);

  assign aw_hs     = bus.AWVALID && aw_ready;
  assign w_hs      = bus.WVALID && w_ready;
  assign b_hs      = b_valid && bus.BREADY;
  assign last_beat = (cnt_q == len_q);
  assign word_idx  = addr_q[ADDR_WIDTH-1:2];
  assign beat_oor  = (word_idx >= (ADDR_WIDTH-2)'(MEM_DEPTH));
  assign DBG_DATA  = mem[DBG_ADDR];

  always_comb begin
    aw_err = (bus.AW_SIZE > 3'd2) || (bus.AW_BURST == 2'b11);
`ifdef AXI_SLV_WRAP_EN
    aw_mask = (ADDR_WIDTH'(1) << bus.AW_SIZE) - ADDR_WIDTH'(1);
    if (bus.AW_BURST == 2'b10) begin
      if (!(bus.AW_LEN inside {4'd1, 4'd3, 4'd7, 4'd15})) aw_err = 1'b1;
      if ((bus.AW_ADDR_q & aw_mask) != '0)               aw_err = 1'b1;
    end
`else
    if (bus.AW_BURST == 2'b10) aw_err = 1'b1;
`endif
  end

  // FIXED and unsupported burst types keep the address where it is
  always_comb begin
    incr      = ADDR_WIDTH'(1) << size_q;
    next_addr = addr_q;
`ifdef AXI_SLV_WRAP_EN
    bound     = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
`endif
    case (burst_q)
      2'b01:   next_addr = addr_q + incr;
`ifdef AXI_SLV_WRAP_EN
      2'b10:   next_addr = (addr_q & ~(bound - ADDR_WIDTH'(1))) |
                           ((addr_q + incr) & (bound - ADDR_WIDTH'(1)));
`endif
      default: next_addr = addr_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    id_d        = id_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    burst_d     = burst_q;
    burst_err_d = burst_err_q;
    slverr_d    = slverr_q;
    decerr_d    = decerr_q;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          addr_d      = bus.AW_ADDR_q;
          id_d        = bus.AW_ID;
          len_d       = bus.AW_LEN;
          size_d      = bus.AW_SIZE;
          burst_d     = bus.AW_BURST;
          cnt_d       = 4'd0;
          burst_err_d = aw_err;
          slverr_d    = aw_err;
          decerr_d    = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          if (beat_oor)          decerr_d = 1'b1;
          else if (!burst_err_q) wr_en    = 1'b1;
          if (bus.W_ID != id_q)       slverr_d = 1'b1;
          if (bus.W_LAST != last_beat) slverr_d = 1'b1;
          addr_d = next_addr;
          cnt_d  = cnt_q + 4'd1;
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      rdy_en_q    <= 1'b0;
      addr_q      <= '0;
      id_q        <= 4'd0;
      len_q       <= 4'd0;
      cnt_q       <= 4'd0;
      size_q      <= 3'd0;
      burst_q     <= 2'd0;
      burst_err_q <= 1'b0;
      slverr_q    <= 1'b0;
      decerr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      addr_q      <= addr_d;
      id_q        <= id_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      burst_err_q <= burst_err_d;
      slverr_q    <= slverr_d;
      decerr_q    <= decerr_d;
    end
  end

  // Memory has no reset so contents survive ARESETn
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (bus.W_STRB[b]) mem[addr_q[IDX_W+1:2]][8*b +: 8] <= bus.W_DATA[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_slv_wr_mem.sv
// tb/tb_axi_slv_wr_mem.sv - scoreboard bench for axi_slv_wr_mem
module tb_axi_slv_wr_mem;
  localparam int BUDGET = 50;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  DBG_ADDR = 4'd0;
  logic [31:0] DBG_DATA;

  int n_checks = 0;
  int n_pass   = 0;
  b_exp_t sb_q[$];

  axi_slv_wr_mem_if #(.ADDR_WIDTH(32)) bus ();

  axi_slv_wr_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .bus      (bus.slave),
    .DBG_ADDR (DBG_ADDR),
    .DBG_DATA (DBG_DATA)
  );

  always #5 ACLK = ~ACLK;

  task automatic push_exp(input logic [3:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id   = id;
    e.resp = resp;
    sb_q.push_back(e);
  endtask

  task automatic peek(input logic [3:0] idx, output logic [31:0] v);
    DBG_ADDR = idx;
    #1;
    v = DBG_DATA;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    bus.AW_ADDR_q = addr;
    bus.AW_ID     = id;
    bus.AW_LEN    = len;
    bus.AW_SIZE   = size;
    bus.AW_BURST  = burst;
    bus.AWVALID   = 1'b1;
    while (bus.AWREADY !== 1'b1 && t < BUDGET) begin
      @(negedge ACLK);
      t++;
    end
    if (t >= BUDGET) begin
      n_checks++;
      $display("FAIL aw_timeout: AWREADY=%b after %0d cycles, required 1", bus.AWREADY, t);
    end
    @(negedge ACLK);
    bus.AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input logic [3:0] id, input int gap);
    int t = 0;
    repeat (gap) @(negedge ACLK);
    bus.W_DATA = data;
    bus.W_STRB = strb;
    bus.W_LAST = last;
    bus.W_ID   = id;
    bus.WVALID = 1'b1;
    while (bus.WREADY !== 1'b1 && t < BUDGET) begin
      @(negedge ACLK);
      t++;
    end
    if (t >= BUDGET) begin
      n_checks++;
      $display("FAIL w_timeout: WREADY=%b after %0d cycles, required 1", bus.WREADY, t);
    end
    @(negedge ACLK);
    bus.WVALID = 1'b0;
  endtask

  task automatic b_recv();
    b_exp_t e;
    int t = 0;
    bus.BREADY = 1'b1;
    while (bus.BVALID !== 1'b1 && t < BUDGET) begin
      @(negedge ACLK);
      t++;
    end
    n_checks++;
    if (t >= BUDGET) begin
      $display("FAIL b_timeout: BVALID=%b after %0d cycles, required 1", bus.BVALID, t);
    end else if (sb_q.size() == 0) begin
      $display("FAIL b_unexpected: got B_ID=%h B_RESP=%b, required no response", bus.B_ID, bus.B_RESP);
    end else begin
      e = sb_q.pop_front();
      if (bus.B_ID !== e.id || bus.B_RESP !== e.resp)
        $display("FAIL b_resp: got id=%h resp=%b, required id=%h resp=%b",
                 bus.B_ID, bus.B_RESP, e.id, e.resp);
      else
        n_pass++;
    end
    @(negedge ACLK);
    bus.BREADY = 1'b0;
  endtask

  task automatic do_burst(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [31:0] base, input logic [3:0] strb, input logic [1:0] resp);
    push_exp(id, resp);
    aw_send(addr, id, len, size, burst);
    for (int i = 0; i <= int'(len); i++)
      w_send(base + 32'(i), strb, (i == int'(len)), id, 0);
    b_recv();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ACLK);
    n_checks++;
    if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b000)
      $display("FAIL reset_ready: AW/W/B=%b, required 000", {bus.AWREADY, bus.WREADY, bus.BVALID});
    else n_pass++;
    n_checks++;
    if ({bus.B_ID, bus.B_RESP} !== 6'd0)
      $display("FAIL reset_bresp: B_ID=%h B_RESP=%b, required 0/00", bus.B_ID, bus.B_RESP);
    else n_pass++;
    ARESETn = 1'b1;
    #1;
    n_checks++;
    if (bus.AWREADY !== 1'b0) $display("FAIL reset_release: AWREADY=%b, required 0", bus.AWREADY);
    else n_pass++;
    @(negedge ACLK);
    n_checks++;
    if (bus.AWREADY !== 1'b1) $display("FAIL reset_first_edge: AWREADY=%b, required 1", bus.AWREADY);
    else n_pass++;
  endtask

  task automatic test_incr();
    logic [31:0] v;
    push_exp(4'h5, 2'b00);
    aw_send(32'h10, 4'h5, 4'd3, 3'd2, 2'b01);
    n_checks++;
    if (bus.WREADY !== 1'b1) $display("FAIL incr_wready: WREADY=%b, required 1", bus.WREADY);
    else n_pass++;
    for (int i = 0; i < 4; i++)
      w_send(32'hA0 + 32'(i), 4'hF, (i == 3), 4'h5, (i == 1) ? 2 : 0);
    n_checks++;
    if ({bus.WREADY, bus.BVALID} !== 2'b01)
      $display("FAIL incr_last_timing: WREADY/BVALID=%b, required 01", {bus.WREADY, bus.BVALID});
    else n_pass++;
    b_recv();
    for (int i = 0; i < 4; i++) begin
      peek(4'(4 + i), v);
      n_checks++;
      if (v !== 32'hA0 + 32'(i)) $display("FAIL incr_mem%0d: got %h, required %h", 4 + i, v, 32'hA0 + 32'(i));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    logic [31:0] exp_w [4];
    do_burst(32'h30, 4'h1, 4'd3, 3'd2, 2'b01, 32'h1111_0000, 4'hF, 2'b00);
`ifdef AXI_SLV_WRAP_EN
    exp_w = '{32'hB2, 32'hB3, 32'hB0, 32'hB1};
    do_burst(32'h38, 4'h2, 4'd3, 3'd2, 2'b10, 32'hB0, 4'hF, 2'b00);
`else
    exp_w = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
    do_burst(32'h38, 4'h2, 4'd3, 3'd2, 2'b10, 32'hB0, 4'hF, 2'b10);
`endif
    for (int i = 0; i < 4; i++) begin
      peek(4'(12 + i), v);
      n_checks++;
      if (v !== exp_w[i]) $display("FAIL wrap_mem%0d: got %h, required %h", 12 + i, v, exp_w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_decerr();
    logic [31:0] v;
    do_burst(32'h0, 4'h3, 4'd0, 3'd2, 2'b01, 32'h5A5A, 4'hF, 2'b00);
    do_burst(32'h3C, 4'h4, 4'd1, 3'd2, 2'b01, 32'hC0, 4'hF, 2'b11);
    peek(4'd15, v);
    n_checks++;
    if (v !== 32'hC0) $display("FAIL decerr_w15: got %h, required %h", v, 32'hC0);
    else n_pass++;
    peek(4'd0, v);
    n_checks++;
    if (v !== 32'h5A5A) $display("FAIL decerr_w0_alias: got %h, required %h", v, 32'h5A5A);
    else n_pass++;
  endtask

  task automatic test_slverr();
    logic [31:0] v;
    push_exp(4'h6, 2'b10);
    aw_send(32'h20, 4'h6, 4'd2, 3'd2, 2'b01);
    w_send(32'hD0, 4'hF, 1'b0, 4'h6, 0);
    w_send(32'hD1, 4'hF, 1'b1, 4'h6, 0);
    w_send(32'hD2, 4'hF, 1'b0, 4'h6, 0);
    b_recv();
    peek(4'd10, v);
    n_checks++;
    if (v !== 32'hD2) $display("FAIL last_err_write: got %h, required %h", v, 32'hD2);
    else n_pass++;
    push_exp(4'h7, 2'b10);
    aw_send(32'h2C, 4'h7, 4'd0, 3'd2, 2'b01);
    w_send(32'hE0, 4'hF, 1'b1, 4'h8, 0);
    b_recv();
    peek(4'd11, v);
    n_checks++;
    if (v !== 32'hE0) $display("FAIL wid_err_write: got %h, required %h", v, 32'hE0);
    else n_pass++;
    do_burst(32'h0C, 4'h1, 4'd0, 3'd2, 2'b01, 32'hFFFF_FFFF, 4'hF, 2'b00);
    do_burst(32'h0C, 4'h1, 4'd0, 3'd2, 2'b01, 32'h1234_5678, 4'b0101, 2'b00);
    peek(4'd3, v);
    n_checks++;
    if (v !== 32'hFF34_FF78) $display("FAIL strobe: got %h, required %h", v, 32'hFF34_FF78);
    else n_pass++;
    do_burst(32'h0C, 4'h9, 4'd0, 3'd3, 2'b01, 32'hDEAD_BEEF, 4'hF, 2'b10);
    do_burst(32'h0C, 4'hD, 4'd0, 3'd2, 2'b11, 32'hDEAD_BEEF, 4'hF, 2'b10);
    peek(4'd3, v);
    n_checks++;
    if (v !== 32'hFF34_FF78) $display("FAIL burst_err_nowrite: got %h, required %h", v, 32'hFF34_FF78);
    else n_pass++;
  endtask

  task automatic test_bready_hold();
    push_exp(4'hA, 2'b00);
    aw_send(32'h18, 4'hA, 4'd0, 3'd2, 2'b01);
    w_send(32'h77, 4'hF, 1'b1, 4'hA, 0);
    bus.AWVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({bus.BVALID, bus.B_ID, bus.B_RESP, bus.AWREADY} !== {1'b1, 4'hA, 2'b00, 1'b0})
        $display("FAIL bready_hold c%0d: BVALID=%b B_ID=%h B_RESP=%b AWREADY=%b, required 1/a/00/0",
                 c, bus.BVALID, bus.B_ID, bus.B_RESP, bus.AWREADY);
      else n_pass++;
      @(negedge ACLK);
    end
    bus.AWVALID = 1'b0;
    b_recv();
    n_checks++;
    if ({bus.AWREADY, bus.BVALID} !== 2'b10)
      $display("FAIL post_b_ready: AWREADY/BVALID=%b, required 10", {bus.AWREADY, bus.BVALID});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    aw_send(32'h0, 4'hB, 4'd3, 3'd2, 2'b01);
    w_send(32'hD0D0_0000, 4'hF, 1'b0, 4'hB, 0);
    w_send(32'hD0D0_0001, 4'hF, 1'b0, 4'hB, 0);
    ARESETn = 1'b0;
    #1;
    n_checks++;
    if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b000)
      $display("FAIL midreset_drop: AW/W/B=%b, required 000", {bus.AWREADY, bus.WREADY, bus.BVALID});
    else n_pass++;
    @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    n_checks++;
    if ({bus.AWREADY, bus.BVALID} !== 2'b10)
      $display("FAIL midreset_idle: AWREADY/BVALID=%b, required 10", {bus.AWREADY, bus.BVALID});
    else n_pass++;
    peek(4'd0, v);
    n_checks++;
    if (v !== 32'hD0D0_0000) $display("FAIL midreset_w0: got %h, required %h", v, 32'hD0D0_0000);
    else n_pass++;
    peek(4'd1, v);
    n_checks++;
    if (v !== 32'hD0D0_0001) $display("FAIL midreset_w1: got %h, required %h", v, 32'hD0D0_0001);
    else n_pass++;
    do_burst(32'h08, 4'hC, 4'd0, 3'd2, 2'b01, 32'h600D, 4'hF, 2'b00);
    peek(4'd2, v);
    n_checks++;
    if (v !== 32'h600D) $display("FAIL midreset_next: got %h, required %h", v, 32'h600D);
    else n_pass++;
  endtask

  initial begin
    bus.AW_ADDR_q = '0;
    bus.AW_ID     = 4'd0;
    bus.AW_LEN    = 4'd0;
    bus.AW_SIZE   = 3'd0;
    bus.AW_BURST  = 2'd0;
    bus.AWVALID   = 1'b0;
    bus.W_DATA    = '0;
    bus.W_STRB    = 4'd0;
    bus.W_LAST    = 1'b0;
    bus.W_ID      = 4'd0;
    bus.WVALID    = 1'b0;
    bus.BREADY    = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_decerr();
    test_slverr();
    test_bready_hold();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: %0d responses missing, required 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
